// File: rtl/urv_trap_ctrl.sv
// urv_trap_ctrl -- machine-mode trap and interrupt controller for the uRV core.
//
// Holds mstatus (MIE/MPIE), mie, mip, mepc and mcause. Sequences exception
// entry, the interrupt request/acknowledge handshake with the execute stage,
// and mret. The committed CSR write value arrives from the CSR read/write unit.
//
// Optional feature macro: URV_TIMER_IRQ_EN
//   defined   -> timer_irq_i port exists, mip[7]/mie[7] implemented, cause 7
//   undefined -> no timer port, mip[7]/mie[7] read 0, only cause 11 raised
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   x_stall_i, x_kill_i     execute stage stall / kill (block commits)
//   x_is_csr_i, x_csr_sel_i CSR instruction and its 12-bit CSR address
//   x_csr_write_value_i     value to commit into the selected CSR
//   x_exception_i/_cause_i/_pc_i  synchronous exception, code, faulting PC
//   x_mret_i                mret in execute
//   x_irq_ack_i, x_irq_pc_i interrupt accepted by the pipeline, resume PC
//   irq_i                   external interrupt (level, asynchronous)
//   timer_irq_i             timer interrupt (level, synchronous; optional)
//   x_irq_o                 interrupt request to execute (registered)
//   x_trap_o                one-cycle pulse after any trap entry
//   x_trap_target_o         constant trap vector
//   csr_*_o                 CSR contents for the read path

module urv_trap_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0008
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        x_is_csr_i,
  input  logic [11:0] x_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic [31:0] x_exception_pc_i,
  input  logic        x_mret_i,
  input  logic        x_irq_ack_i,
  input  logic [31:0] x_irq_pc_i,
  input  logic        irq_i,
`ifdef URV_TIMER_IRQ_EN
  input  logic        timer_irq_i,
`endif
  output logic        x_irq_o,
  output logic        x_trap_o,
  output logic [31:0] x_trap_target_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o
);

  localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ID_MIE     = 12'h304;
  localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REQ  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_irq_sync1;
  logic        r_irq_sync2;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_meie;
  logic [29:0] r_mepc;
  logic        r_mcause_int;
  logic [3:0]  r_mcause_code;
  logic        r_trap;

  logic        w_go;
  logic        w_meip;
  logic        w_mtip;
  logic        w_mtie;
  logic        w_irq_cond;
  logic        w_exc_take;
  logic        w_ack_take;
  logic        w_mret_take;
  logic        w_csr_take;
  logic [3:0]  w_irq_code;
  logic        w_unused_bits;

  assign w_go   = !x_stall_i && !x_kill_i;
  assign w_meip = r_irq_sync2;

  // Low PC/value bits never reach any architectural field.
  assign w_unused_bits = &{1'b0, x_csr_write_value_i[1:0],
                           x_exception_pc_i[1:0], x_irq_pc_i[1:0]};

  // irq_i is asynchronous: two-flop synchronizer feeds mip.MEIP.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_irq_sync1 <= 1'b0;
      r_irq_sync2 <= 1'b0;
    end else begin
      r_irq_sync1 <= irq_i;
      r_irq_sync2 <= r_irq_sync1;
    end
  end

`ifdef URV_TIMER_IRQ_EN
  logic r_timer_irq;
  logic r_mtie;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_timer_irq <= 1'b0;
    else          r_timer_irq <= timer_irq_i;
  end

  assign w_mtip = r_timer_irq;
  assign w_mtie = r_mtie;
`else
  assign w_mtip = 1'b0;
  assign w_mtie = 1'b0;
`endif

  assign w_irq_cond = r_mstatus_mie && ((w_meip && r_meie) || (w_mtip && w_mtie));
  // External interrupt wins over timer.
  assign w_irq_code = (w_meip && r_meie) ? 4'd11 : 4'd7;

  // Event arbitration: exception > irq ack > mret > CSR write.
  assign w_exc_take  = w_go && x_exception_i;
  assign w_ack_take  = (r_state == ST_REQ) && x_irq_ack_i && !w_exc_take;
  assign w_mret_take = w_go && x_mret_i && !w_exc_take && !w_ack_take;
  assign w_csr_take  = w_go && x_is_csr_i && !w_exc_take && !w_ack_take && !w_mret_take;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (w_exc_take || w_ack_take) begin
      w_state_next = ST_TRAP;
    end else begin
      case (r_state)
        ST_RUN:  if (w_irq_cond)  w_state_next = ST_REQ;
        ST_REQ:  if (!w_irq_cond) w_state_next = ST_RUN;
        ST_TRAP: if (w_mret_take) w_state_next = ST_RUN;
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    x_irq_o         = (r_state == ST_REQ);
    x_trap_o        = r_trap;
    x_trap_target_o = TRAP_VECTOR;
    csr_mstatus_o   = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
    csr_mie_o       = {20'b0, r_meie, 3'b0, w_mtie, 7'b0};
    csr_mip_o       = {20'b0, w_meip, 3'b0, w_mtip, 7'b0};
    csr_mepc_o      = {r_mepc, 2'b00};
    csr_mcause_o    = {r_mcause_int, 27'b0, r_mcause_code};
  end

  // Architectural CSR state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_meie         <= 1'b0;
`ifdef URV_TIMER_IRQ_EN
      r_mtie         <= 1'b0;
`endif
      r_mepc         <= '0;
      r_mcause_int   <= 1'b0;
      r_mcause_code  <= '0;
      r_trap         <= 1'b0;
    end else begin
      r_trap <= w_exc_take || w_ack_take;
      if (w_exc_take) begin
        r_mepc        <= x_exception_pc_i[31:2];
        r_mcause_int  <= 1'b0;
        r_mcause_code <= x_exception_cause_i;
        // Nested exception inside the handler keeps the saved interrupt state.
        if (r_state != ST_TRAP) begin
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
        end
      end else if (w_ack_take) begin
        r_mepc         <= x_irq_pc_i[31:2];
        r_mcause_int   <= 1'b1;
        r_mcause_code  <= w_irq_code;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_mret_take) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_csr_take) begin
        case (x_csr_sel_i)
          CSR_ID_MSTATUS: begin
            r_mstatus_mie  <= x_csr_write_value_i[3];
            r_mstatus_mpie <= x_csr_write_value_i[7];
          end
          CSR_ID_MIE: begin
            r_meie <= x_csr_write_value_i[11];
`ifdef URV_TIMER_IRQ_EN
            r_mtie <= x_csr_write_value_i[7];
`endif
          end
          CSR_ID_MEPC: r_mepc <= x_csr_write_value_i[31:2];
          CSR_ID_MCAUSE: begin
            r_mcause_int  <= x_csr_write_value_i[31];
            r_mcause_code <= x_csr_write_value_i[3:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urv_trap_ctrl.sv
module tb_urv_trap_ctrl;

  localparam logic [11:0] ID_MSTATUS = 12'h300;
  localparam logic [11:0] ID_MIE     = 12'h304;
  localparam logic [11:0] ID_MIP     = 12'h344;
  localparam logic [11:0] ID_MEPC    = 12'h341;
  localparam logic [11:0] ID_MCAUSE  = 12'h342;

`ifdef URV_TIMER_IRQ_EN
  localparam logic [31:0] MIE_880_RD = 32'h0000_0880;
`else
  localparam logic [31:0] MIE_880_RD = 32'h0000_0800;
`endif

  logic        clk;
  logic        rst_n;
  logic        x_stall, x_kill, x_is_csr, x_exception, x_mret, x_irq_ack, irq;
  logic [11:0] x_csr_sel;
  logic [31:0] x_csr_wval, x_exc_pc, x_irq_pc;
  logic [3:0]  x_exc_cause;
  logic        x_irq, x_trap;
  logic [31:0] x_trap_target, mstatus, mip, mie, mepc, mcause;
`ifdef URV_TIMER_IRQ_EN
  logic        timer_irq;
`endif

  int checks = 0;
  int errors = 0;

  urv_trap_ctrl #(.TRAP_VECTOR(32'h0000_0008)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .x_stall_i           (x_stall),
    .x_kill_i            (x_kill),
    .x_is_csr_i          (x_is_csr),
    .x_csr_sel_i         (x_csr_sel),
    .x_csr_write_value_i (x_csr_wval),
    .x_exception_i       (x_exception),
    .x_exception_cause_i (x_exc_cause),
    .x_exception_pc_i    (x_exc_pc),
    .x_mret_i            (x_mret),
    .x_irq_ack_i         (x_irq_ack),
    .x_irq_pc_i          (x_irq_pc),
    .irq_i               (irq),
`ifdef URV_TIMER_IRQ_EN
    .timer_irq_i         (timer_irq),
`endif
    .x_irq_o             (x_irq),
    .x_trap_o            (x_trap),
    .x_trap_target_o     (x_trap_target),
    .csr_mstatus_o       (mstatus),
    .csr_mip_o           (mip),
    .csr_mie_o           (mie),
    .csr_mepc_o          (mepc),
    .csr_mcause_o        (mcause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sel;
    logic [31:0] wval;
    logic [31:0] exp_mstatus;
    logic [31:0] exp_mie;
    logic [31:0] exp_mepc;
    logic [31:0] exp_mcause;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
    x_is_csr = 1'b1; x_csr_sel = sel; x_csr_wval = val;
    tick();
    x_is_csr = 1'b0;
  endtask

  // Bounded wait for the interrupt request; timeout counts as a failure.
  task automatic wait_irq(input string name);
    int n;
    n = 0;
    while (!x_irq && n < 10) begin
      tick();
      n++;
    end
    check(name, {31'b0, x_irq}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    x_stall = 0; x_kill = 0; x_is_csr = 0; x_exception = 0; x_mret = 0;
    x_irq_ack = 0; irq = 0; x_csr_sel = '0; x_csr_wval = '0;
    x_exc_pc = '0; x_irq_pc = '0; x_exc_cause = '0;
`ifdef URV_TIMER_IRQ_EN
    timer_irq = 0;
`endif

    vecs[0] = '{ID_MSTATUS, 32'hFFFF_FFFF, 32'h88, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{ID_MEPC,    32'h1234_5677, 32'h88, 32'h0, 32'h1234_5674, 32'h0};
    vecs[2] = '{ID_MCAUSE,  32'hFFFF_FFFF, 32'h88, 32'h0, 32'h1234_5674, 32'h8000_000F};
    vecs[3] = '{ID_MIE,     32'h0000_0880, 32'h88, MIE_880_RD, 32'h1234_5674, 32'h8000_000F};
    vecs[4] = '{ID_MIP,     32'hFFFF_FFFF, 32'h88, MIE_880_RD, 32'h1234_5674, 32'h8000_000F};
    vecs[5] = '{ID_MSTATUS, 32'h0000_0008, 32'h08, MIE_880_RD, 32'h1234_5674, 32'h8000_000F};
    vecs[6] = '{ID_MSTATUS, 32'h0000_0080, 32'h80, MIE_880_RD, 32'h1234_5674, 32'h8000_000F};
    vecs[7] = '{ID_MCAUSE,  32'h7FFF_FFF2, 32'h80, MIE_880_RD, 32'h1234_5674, 32'h2};
    vecs[8] = '{ID_MIE,     32'h0000_0000, 32'h80, 32'h0, 32'h1234_5674, 32'h2};
    vecs[9] = '{ID_MEPC,    32'hFFFF_FFFF, 32'h80, 32'h0, 32'hFFFF_FFFC, 32'h2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_mstatus", mstatus, 32'h0);
    check("rst_mie", mie, 32'h0);
    check("rst_mip", mip, 32'h0);
    check("rst_mepc", mepc, 32'h0);
    check("rst_mcause", mcause, 32'h0);
    check("rst_irq", {31'b0, x_irq}, 32'h0);
    check("rst_trap", {31'b0, x_trap}, 32'h0);
    check("trap_target", x_trap_target, 32'h8);

    // CSR write table
    for (int i = 0; i < 10; i++) begin
      csr_write(vecs[i].sel, vecs[i].wval);
      check($sformatf("vec%0d_mstatus", i), mstatus, vecs[i].exp_mstatus);
      check($sformatf("vec%0d_mie", i), mie, vecs[i].exp_mie);
      check($sformatf("vec%0d_mepc", i), mepc, vecs[i].exp_mepc);
      check($sformatf("vec%0d_mcause", i), mcause, vecs[i].exp_mcause);
    end

    // External interrupt latency and acknowledge
    csr_write(ID_MSTATUS, 32'h8);
    csr_write(ID_MIE, 32'h800);
    irq = 1'b1;
    tick();
    check("irq_mip_n", mip, 32'h0);
    tick();
    check("irq_mip_n1", mip, 32'h800);
    check("irq_req_n1", {31'b0, x_irq}, 32'h0);
    tick();
    check("irq_req_n2", {31'b0, x_irq}, 32'h1);
    x_irq_ack = 1'b1; x_irq_pc = 32'h100;
    tick();
    x_irq_ack = 1'b0; irq = 1'b0;
    check("ack_mepc", mepc, 32'h100);
    check("ack_mcause", mcause, 32'h8000_000B);
    check("ack_mstatus", mstatus, 32'h80);
    check("ack_irq_low", {31'b0, x_irq}, 32'h0);
    check("ack_trap_pulse", {31'b0, x_trap}, 32'h1);
    tick();
    check("ack_trap_end", {31'b0, x_trap}, 32'h0);
    tick();
    x_mret = 1'b1;
    tick();
    x_mret = 1'b0;
    check("mret_mstatus", mstatus, 32'h88);

    // Exception blocked by stall and kill, then committed
    x_exception = 1'b1; x_exc_cause = 4'd2; x_exc_pc = 32'h40; x_stall = 1'b1;
    tick();
    check("stall_mepc", mepc, 32'h100);
    check("stall_mcause", mcause, 32'h8000_000B);
    check("stall_trap", {31'b0, x_trap}, 32'h0);
    x_stall = 1'b0; x_kill = 1'b1;
    tick();
    check("kill_mepc", mepc, 32'h100);
    x_kill = 1'b0;
    tick();
    x_exception = 1'b0;
    check("exc_mepc", mepc, 32'h40);
    check("exc_mcause", mcause, 32'h2);
    check("exc_mstatus", mstatus, 32'h80);
    check("exc_trap", {31'b0, x_trap}, 32'h1);
    x_mret = 1'b1;
    tick();
    x_mret = 1'b0;
    check("exc_mret_mstatus", mstatus, 32'h88);

    // Exception and ack in the same cycle
    irq = 1'b1;
    wait_irq("sim_req");
    x_exception = 1'b1; x_exc_cause = 4'd3; x_exc_pc = 32'h80;
    x_irq_ack = 1'b1; x_irq_pc = 32'h200;
    tick();
    x_exception = 1'b0; x_irq_ack = 1'b0;
    check("sim_mcause", mcause, 32'h3);
    check("sim_mepc", mepc, 32'h80);
    check("sim_irq_low", {31'b0, x_irq}, 32'h0);
    check("sim_trap", {31'b0, x_trap}, 32'h1);
    // Still in TRAP: re-enabling MIE must not raise a request
    csr_write(ID_MSTATUS, 32'h88);
    repeat (3) tick();
    check("trap_no_req", {31'b0, x_irq}, 32'h0);
    x_mret = 1'b1;
    tick();
    x_mret = 1'b0;
    check("trap_mret_irq", {31'b0, x_irq}, 32'h0);
    tick();
    check("run_to_req", {31'b0, x_irq}, 32'h1);
    // Condition drops: REQ -> RUN once the synchronizer clears
    irq = 1'b0;
    tick();
    tick();
    check("drop_hold", {31'b0, x_irq}, 32'h1);
    tick();
    check("drop_run", {31'b0, x_irq}, 32'h0);

    // Asynchronous reset mid-REQ
    irq = 1'b1;
    wait_irq("rst_req");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irq", {31'b0, x_irq}, 32'h0);
    check("arst_mstatus", mstatus, 32'h0);
    check("arst_mie", mie, 32'h0);
    check("arst_mip", mip, 32'h0);
    check("arst_mepc", mepc, 32'h0);
    check("arst_mcause", mcause, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_rel_irq", {31'b0, x_irq}, 32'h0);
    csr_write(ID_MSTATUS, 32'h8);
    csr_write(ID_MIE, 32'h800);
    tick();
    check("arst_run_req", {31'b0, x_irq}, 32'h1);
    irq = 1'b0;
    repeat (3) tick();
    check("arst_idle", {31'b0, x_irq}, 32'h0);

    // mret beats a CSR write in the same cycle (MIE=1, MPIE=0 here)
    x_mret = 1'b1; x_is_csr = 1'b1; x_csr_sel = ID_MSTATUS; x_csr_wval = 32'h0;
    tick();
    x_mret = 1'b0; x_is_csr = 1'b0;
    check("mret_vs_csr", mstatus, 32'h80);

`ifdef URV_TIMER_IRQ_EN
    // Timer + external together: external has priority
    csr_write(ID_MSTATUS, 32'h8);
    csr_write(ID_MIE, 32'h880);
    timer_irq = 1'b1; irq = 1'b1;
    wait_irq("tmr_ext_req");
    x_irq_ack = 1'b1; x_irq_pc = 32'h300;
    tick();
    x_irq_ack = 1'b0;
    check("tmr_ext_mcause", mcause, 32'h8000_000B);
    irq = 1'b0;
    repeat (3) tick();
    x_mret = 1'b1;
    tick();
    x_mret = 1'b0;
    wait_irq("tmr_req");
    x_irq_ack = 1'b1;
    tick();
    x_irq_ack = 1'b0;
    timer_irq = 1'b0;
    check("tmr_mcause", mcause, 32'h8000_0007);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
